i2c_dac_stream_seq: RTL

//  Parametrised waveform sequencer for the I2C master logic. It reads 8-bit samples from a

---
 rtl/i2c_dac_stream_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/i2c_dac_stream_seq.sv
// I2C DAC waveform sequencer: streams wave ROM samples to a PCF8591-class DAC as burst
// continuous-write transactions, with loop/one-shot modes, inter-burst gap and NACK abort.
module i2c_dac_stream_seq #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned ROM_DEPTH = 256,
   parameter logic [6:0]  DEV_ADDR  = 7'h48,
   parameter logic [7:0]  CTRL_BYTE = 8'h40,
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned GAP_CYC   = 0
) (
   input  logic              clk_12m,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              one_shot,
   input  logic              i2c_busy,
   input  logic              i2c_byte_req,
   input  logic              i2c_done,
   input  logic              i2c_nack,
   output logic              i2c_start,
   output logic [7:0]        i2c_config,
   output logic [6:0]        i2c_dev_addr,
   output logic [7:0]        i2c_reg_addr,
   output logic [7:0]        i2c_reg_data,
   output logic              i2c_last,
   output logic [ADDR_W-1:0] wave_rom_address,
   input  logic [7:0]        wave_rom_data,
   output logic              running,
   output logic              pass_done,
   output logic              error
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] FETCH     = 3'd1;
   localparam logic [2:0] LOAD      = 3'd2;
   localparam logic [2:0] START     = 3'd3;
   localparam logic [2:0] STREAM    = 3'd4;
   localparam logic [2:0] STOP_WAIT = 3'd5;
   localparam logic [2:0] GAP       = 3'd6;

   localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned GW = (GAP_CYC > 3) ? $clog2(GAP_CYC) : 2;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);
   localparam logic [BW-1:0]     LAST_BYTE = BW'(BURST_LEN - 1);
   localparam logic [GW-1:0]     GAP_LOAD  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   // FETCH, LOAD and START overlap the tail of the gap count
   localparam logic [GW-1:0]     PIPE_CYC  = GW'(3);

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr, addr_next;
   logic [BW-1:0]     burst_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [7:0]        data_q;
   logic              os, pass_end, mid, last_q, start_q, pass_q, err_q;
   logic              active, advance, finish, exit_idle, wrap_end;
   logic [2:0]        done_next;

   assign active    = (state != IDLE);
   assign addr_next = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
   assign wrap_end  = os && (addr == LAST_ADDR);
   // ROM sees the next address in the req cycle so new data lands 2 cycles after the req
   assign advance   = (state == STREAM) && i2c_byte_req && !i2c_done && !i2c_nack;
   assign finish    = i2c_done && ((state == STOP_WAIT) || (state == STREAM) ||
                                   ((state == LOAD) && mid));
   assign exit_idle = pass_end || !enable || err_q;
   assign done_next = exit_idle ? IDLE : ((GAP_CYC > 0) ? GAP : FETCH);

   assign wave_rom_address = advance ? addr_next : addr;
   assign i2c_config       = active ? 8'h02 : '0;
   assign i2c_dev_addr     = active ? DEV_ADDR : '0;
   assign i2c_reg_addr     = active ? CTRL_BYTE : '0;
   assign i2c_reg_data     = data_q;
   assign i2c_last         = last_q && ((state == STREAM) || (state == START));
   assign i2c_start        = start_q;
   assign running          = active;
   assign pass_done        = pass_q;
   assign error            = err_q;

   always_ff @(posedge clk_12m or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         burst_cnt <= '0;
         gap_cnt   <= '0;
         data_q    <= '0;
         os        <= 1'b0;
         pass_end  <= 1'b0;
         mid       <= 1'b0;
         last_q    <= 1'b0;
         start_q   <= 1'b0;
         pass_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         start_q <= 1'b0;
         pass_q  <= 1'b0;
         if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
         if (active && i2c_nack) begin
            err_q  <= 1'b1;
            last_q <= 1'b0;
            state  <= i2c_done ? IDLE : STOP_WAIT;
         end else if (finish) begin
            last_q  <= 1'b0;
            pass_q  <= pass_end;
            gap_cnt <= GAP_LOAD;
            state   <= done_next;
         end else begin
            case (state)
               IDLE: begin
                  gap_cnt <= '0;
                  last_q  <= 1'b0;
                  if (!enable) begin
                     err_q <= 1'b0;
                  end else if (!err_q) begin
                     addr  <= '0;
                     os    <= one_shot;
                     state <= FETCH;
                  end
               end
               FETCH: begin
                  burst_cnt <= '0;
                  pass_end  <= 1'b0;
                  mid       <= 1'b0;
                  state     <= LOAD;
               end
               LOAD: begin
                  data_q <= wave_rom_data;
                  last_q <= (burst_cnt == LAST_BYTE) || wrap_end;
                  state  <= mid ? STREAM : START;
               end
               START: begin
                  if (!i2c_busy && (gap_cnt == '0)) begin
                     start_q   <= 1'b1;
                     burst_cnt <= '0;
                     mid       <= 1'b1;
                     state     <= STREAM;
                  end
               end
               STREAM: begin
                  if (i2c_byte_req) begin
                     if (last_q) begin
                        pass_end <= wrap_end;
                        if (!wrap_end) addr <= addr_next;
                        last_q   <= 1'b0;
                        state    <= STOP_WAIT;
                     end else begin
                        addr      <= addr_next;
                        burst_cnt <= burst_cnt + BW'(1);
                        state     <= LOAD;
                     end
                  end
               end
               STOP_WAIT: ;
               GAP: begin
                  if (!enable) state <= IDLE;
                  else if (gap_cnt <= PIPE_CYC) state <= FETCH;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
